// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared mode codes and FSM state encoding for the down counter
package down_counter_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_HOLD    = 2'b10;
  localparam logic [1:0] MODE_ZERO    = 2'b11;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler emitting a one-clk tick every DIV clocks
module tick_gen #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic Clear,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  // count 0..DIV-1 and wrap; only Clear restarts the phase
  always_ff @(posedge clk) begin
    if (Clear) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/four_bit_down_counter.sv
// four_bit_down_counter: loadable tick-paced down counter with wrap/one-shot/hold/zero modes; DOWN_COUNTER_AUTORELOAD_EN makes one-shot periodic
module four_bit_down_counter
  import down_counter_pkg::*;
#(
  parameter int unsigned DIV   = 50_000_000,
  parameter int          WIDTH = 4
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic [1:0]       sel,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             zero,
  output logic             done
);
  logic             tick;
  logic             run_tick;
  logic             expire;
  logic             rearm;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] q_nxt;
  state_t           st;
  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .Clear(Clear),
    .tick (tick)
  );
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  assign rearm = reload != '0;
`else
  assign rearm = 1'b0;
`endif
  assign run_tick = sel == MODE_ONESHOT && st == S_RUN && tick;
  assign expire   = run_tick && Q == WIDTH'(1);
  // next count: load beats mode action; zero mode is not tick-gated
  always_comb begin
    q_nxt = load                      ? load_val :
            sel == MODE_ZERO          ? '0 :
            sel == MODE_WRAP && tick  ? Q - 1'b1 :
            expire                    ? (rearm ? reload : '0) :
            run_tick                  ? Q - 1'b1 : Q;
  end
  // count, flags, reload register and one-shot FSM; zero tracks next-state Q
  always_ff @(posedge clk) begin
    if (Clear) begin
      Q      <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
      reload <= '0;
      st     <= S_IDLE;
    end else begin
      Q    <= q_nxt;
      zero <= q_nxt == '0;
      done <= !load && expire;
      if (load) begin
        reload <= load_val;
        st     <= (sel == MODE_ONESHOT && load_val != '0) ? S_RUN : S_IDLE;
      end else begin
        case (sel)
          MODE_ONESHOT: begin
            if (st == S_IDLE && tick && Q != '0) st <= S_RUN;
            else if (expire && !rearm) st <= S_DONE;
          end
          MODE_HOLD: ;
          default: st <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_four_bit_down_counter.sv
// tb_four_bit_down_counter: scoreboard bench for the down counter at DIV=4
module tb_four_bit_down_counter;
  localparam int DIV = 4;
  typedef struct {
    string      tag;
    logic [3:0] q;
    logic       z;
    logic       d;
  } exp_t;
  logic       clk = 1'b0;
  logic       Clear;
  logic [1:0] sel;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] Q;
  logic       zero;
  logic       done;
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         ph = 0;
  logic [3:0] exp_q = '0;
  four_bit_down_counter #(.DIV(DIV), .WIDTH(4)) dut (
    .clk     (clk),
    .Clear   (Clear),
    .sel     (sel),
    .load    (load),
    .load_val(load_val),
    .Q       (Q),
    .zero    (zero),
    .done    (done)
  );
  always #5 clk = ~clk;
  // bench's own view of the tick phase: a tick edge follows a cycle with ph==DIV-1
  always @(posedge clk) ph <= Clear ? 0 : (ph == DIV - 1 ? 0 : ph + 1);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic edge_chk(input string tag, input logic [3:0] q, input logic d);
    exp_t e;
    sb.push_back('{tag, q, q == 4'd0, d});
    exp_q = q;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_q"}, Q, e.q);
      chk({e.tag, "_zero"}, zero, e.z);
      chk({e.tag, "_done"}, done, e.d);
    end
  endtask
  task automatic tick_chk(input string tag, input logic [3:0] q, input logic d);
    int n = 0;
    while (ph != DIV - 1 && n < 2 * DIV) begin
      edge_chk(tag, exp_q, 1'b0);
      n++;
    end
    if (n >= 2 * DIV) chk({tag, "_tick_timeout"}, 1, 0);
    edge_chk(tag, q, d);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    Clear = 1; load = 1; load_val = 4'd9; sel = 2'b01;
    edge_chk("rst", 4'd0, 1'b0);
    edge_chk("rst", 4'd0, 1'b0);
    Clear = 0; load = 1; load_val = 4'd2; sel = 2'b00;
    edge_chk("wrap_ld", 4'd2, 1'b0);
    load = 0;
    tick_chk("wrap", 4'd1, 1'b0);
    tick_chk("wrap", 4'd0, 1'b0);
    tick_chk("wrap", 4'd15, 1'b0);
    tick_chk("wrap", 4'd14, 1'b0);
    load = 1; load_val = 4'd3; sel = 2'b01;
    edge_chk("os_ld", 4'd3, 1'b0);
    load = 0;
    tick_chk("os", 4'd2, 1'b0);
    tick_chk("os", 4'd1, 1'b0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    tick_chk("os_exp", 4'd3, 1'b1);
    edge_chk("os_pulse", 4'd3, 1'b0);
`else
    tick_chk("os_exp", 4'd0, 1'b1);
    edge_chk("os_pulse", 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick_chk("os_stay", 4'd0, 1'b0);
`endif
    load = 1; load_val = 4'd5; sel = 2'b01;
    edge_chk("hold_ld", 4'd5, 1'b0);
    load = 0;
    tick_chk("hold_run", 4'd4, 1'b0);
    tick_chk("hold_run", 4'd3, 1'b0);
    sel = 2'b10;
    for (int i = 0; i < 3; i++) tick_chk("hold", 4'd3, 1'b0);
    sel = 2'b01;
    tick_chk("resume", 4'd2, 1'b0);
    tick_chk("resume", 4'd1, 1'b0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    tick_chk("resume_exp", 4'd5, 1'b1);
`else
    tick_chk("resume_exp", 4'd0, 1'b1);
`endif
    edge_chk("resume_pulse", exp_q, 1'b0);
    load = 1; load_val = 4'd6; sel = 2'b01;
    edge_chk("mid_ld", 4'd6, 1'b0);
    load = 0;
    tick_chk("mid", 4'd5, 1'b0);
    tick_chk("mid", 4'd4, 1'b0);
    load = 1; load_val = 4'd7;
    edge_chk("mid_reload", 4'd7, 1'b0);
    Clear = 1; load_val = 4'd9;
    edge_chk("clr_vs_ld", 4'd0, 1'b0);
    Clear = 0; load_val = 4'd8; sel = 2'b00;
    edge_chk("zm_ld", 4'd8, 1'b0);
    load = 0;
    tick_chk("zm", 4'd7, 1'b0);
    sel = 2'b11;
    edge_chk("zm_zero", 4'd0, 1'b0);
    edge_chk("zm_zero", 4'd0, 1'b0);
    tick_chk("zm_zero", 4'd0, 1'b0);
    load = 1; load_val = 4'd4; sel = 2'b10;
    edge_chk("idle_ld", 4'd4, 1'b0);
    load = 0; sel = 2'b01;
    tick_chk("idle_arm", 4'd4, 1'b0);
    tick_chk("idle_run", 4'd3, 1'b0);
    load = 1; load_val = 4'd0;
    edge_chk("ld0", 4'd0, 1'b0);
    load = 0;
    tick_chk("ld0", 4'd0, 1'b0);
    tick_chk("ld0", 4'd0, 1'b0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    load = 1; load_val = 4'd2;
    edge_chk("ar_ld", 4'd2, 1'b0);
    load = 0;
    tick_chk("ar", 4'd1, 1'b0);
    tick_chk("ar", 4'd2, 1'b1);
    tick_chk("ar", 4'd1, 1'b0);
    tick_chk("ar", 4'd2, 1'b1);
    load = 1; load_val = 4'd0;
    edge_chk("ar_ld0", 4'd0, 1'b0);
    load = 0;
    tick_chk("ar_ld0", 4'd0, 1'b0);
    tick_chk("ar_ld0", 4'd0, 1'b0);
`endif
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/four_bit_down_counter.md
Name: four_bit_down_counter

Overview:
- 4-bit loadable down counter; the count-down counterpart of the board-level 4-bit up counter.
- Counts on a one-cycle tick from an internal prescaler (1 Hz on the 50 MHz board clock) so the LEDs change visibly.
- Supports free-running wrap mode and a one-shot countdown mode that stops at zero with a done pulse.
- Drives board LEDs directly; also serves as a countdown timer for demo top levels.

Parameters:
- DIV, 50_000_000, clk cycles per count tick (legal range 2..2^32-1); benches use DIV=4.
- WIDTH, 4, counter width; only 4 is required and verified.

Ports:
- clk  input  1  board clock; all logic on its rising edge.
- Clear  input  1  synchronous active-high reset; clears counter, prescaler, FSM.
- sel  input  2  mode: 00 wrap-down, 01 one-shot down, 10 hold, 11 idle/zero.
- load  input  1  level; when high, the count register takes load_val at the next edge.
- load_val  input  WIDTH  value loaded into Q and into the reload register.
- Q  output  WIDTH  current count (registered).
- zero  output  1  registered; high when Q==0.
- done  output  1  registered one-clk pulse when one-shot reaches 0.

Behaviour:
- Reset (Clear=1 at posedge clk): Q=0, zero=1, done=0, prescaler count=0, reload register=0, state=IDLE. Clear overrides load and sel.
- Prescaler: counter 0..DIV-1, wraps; tick=1 for exactly one clk when count==DIV-1. Prescaler free-runs in all modes; only Clear resets it.
- Priority per edge: Clear > load > mode action.
- load=1: Q<=load_val, reload<=load_val, done<=0. The FSM goes to RUN if sel==01 and load_val!=0, else IDLE. The prescaler is not restarted.
- FSM states IDLE, RUN, DONE (used for sel==01 only):
  - IDLE->RUN: sel==01, Q!=0, tick.
  - RUN: each tick Q<=Q-1. If Q==1 on the tick, then Q<=0, done<=1 for one clk, ->DONE.
  - DONE: Q holds 0. Leaves only on load (->RUN/IDLE as above) or a sel change (->IDLE).
- sel==00: each tick Q<=Q-1, wrapping 0->15. done is never asserted. FSM forced to IDLE.
- sel==10: Q holds; ticks ignored. FSM holds state, so one-shot resumes when sel returns to 01 from RUN.
- sel==11: Q<=0 on the next clk (not tick-gated). FSM->IDLE.
- sel changes mid-run take effect on the next edge. done is never generated by a mode change.
- zero is registered from next-state Q, so it is aligned with Q.
- All arithmetic is modulo 2^WIDTH. Latency: Q changes on the clk edge where tick==1 is sampled.

Optional Feature:
- Macro DOWN_COUNTER_AUTORELOAD_EN.
- Defined: in one-shot mode, at expiry Q<=reload (instead of staying at 0), done pulses, and the FSM stays in RUN, giving a periodic timer. If reload==0, behaviour matches the undefined case.
- Undefined: the reload register still captures load_val, but expiry stops at 0 in DONE as specified above.

Decomposition:
- Package down_counter_pkg holds:
  - mode localparams MODE_WRAP=2'b00, MODE_ONESHOT=2'b01, MODE_HOLD=2'b10, MODE_ZERO=2'b11;
  - FSM state encodings S_IDLE, S_RUN, S_DONE (2-bit).
- Sub-module tick_gen (parameter DIV; ports clk, Clear, tick) contains the prescaler. It is reusable by the up counter in place of its divided-clock scheme.

Test Plan:
- Reset: DIV=4, Clear high 2 clk with load=1, load_val=9 -> Q=0, zero=1, done=0; load ignored.
- Wrap-down: load 2, sel=00 -> Q goes 2,1,0,15,14 on successive ticks (every 4 clk); done stays 0.
- One-shot: load 3, sel=01 -> Q goes 3,2,1,0. done pulses one clk on the 1->0 tick; Q stays 0 over 5 further ticks; zero=1.
- Hold/resume: one-shot from 5, sel=10 after Q=3 for 3 ticks -> Q stays 3. Then sel=01 -> Q goes 2,1,0 with done.
- Load vs Clear vs mid-run: load 7 while at Q=4 in RUN -> Q=7 next clk. Clear and load in the same clk -> Q=0. sel=11 -> Q=0 next clk with no done.
- With DOWN_COUNTER_AUTORELOAD_EN: load 2, sel=01 -> Q goes 2,1,2,1,2 with a done pulse each 1->reload tick. Load 0 -> Q stays 0, no done.
